// File: rtl/arb_pkg.sv
// Shared types and policy constants for the L2 request arbiter.
package arb_pkg;

   // Arbiter state: IDLE has no owner, GRANT means the owner register is valid.
   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   // Winner selection policies.
   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

endpackage

// File: rtl/arb_priority_pick.sv
// Rotating priority picker: first active requester at or after i_start wins.
module arb_priority_pick #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_active,
   input  logic [IDX_W-1:0]   i_start,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_valid
);

   // Walk the requesters from i_start with wrap-around and keep the first hit.
   always_comb begin
      int w_cand;
      w_cand  = 0;
      o_idx   = '0;
      o_valid = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = int'(i_start) + k;
         if (w_cand >= NUM_REQ) begin
            w_cand = w_cand - NUM_REQ;
         end
         if (!o_valid && i_active[w_cand]) begin
            o_valid = 1'b1;
            o_idx   = IDX_W'(w_cand);
         end
      end
   end

endmodule

// File: rtl/l2_request_arbiter.sv
// N-way arbiter between the L1 caches / memory clients and the shared L2 port.
// Grants are non-preemptive; a single IDLE cycle separates transactions so the
// finishing requester can drop its level request before re-arbitration.
module l2_request_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256,
   parameter int RR_MODE    = ARB_FIXED
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_read,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*LINE_WIDTH-1:0] req_wdata,
   output logic [LINE_WIDTH-1:0]         req_rdata,
   output logic [NUM_REQ-1:0]            req_resp,
   output logic                          mem_read,
   output logic                          mem_write,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [LINE_WIDTH-1:0]         mem_wdata,
   input  logic [LINE_WIDTH-1:0]         mem_rdata,
   input  logic                          mem_resp,
   output logic [$clog2(NUM_REQ)-1:0]    owner,
   output logic                          busy
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   arb_state_e            r_state;
   arb_state_e            w_state_next;
   logic [IDX_W-1:0]      r_owner;
   logic [IDX_W-1:0]      r_last_grant;
   logic [IDX_W-1:0]      w_start;
   logic [IDX_W-1:0]      w_win_idx;
   logic                  w_win_valid;
   logic                  w_busy;
   logic                  w_owner_active;
   logic [NUM_REQ-1:0]    w_active;
   logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
   logic [LINE_WIDTH-1:0] w_wdata_arr [NUM_REQ];

   // Unpack per-requester slices and build the one-hot completion strobe.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign w_active[gi]    = req_read[gi] | req_write[gi];
         assign w_addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign w_wdata_arr[gi] = req_wdata[gi*LINE_WIDTH +: LINE_WIDTH];
         assign req_resp[gi]    = w_busy & mem_resp & (r_owner == IDX_W'(gi));
      end
   endgenerate

   // Round-robin searches from the slot after the last winner; fixed priority from 0.
   assign w_start = ((RR_MODE == ARB_RR) && (r_last_grant != LAST_IDX)) ?
                    r_last_grant + 1'b1 : '0;

   arb_priority_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .i_active (w_active),
      .i_start  (w_start),
      .o_idx    (w_win_idx),
      .o_valid  (w_win_valid)
   );

   assign w_busy         = (r_state == ARB_GRANT);
   assign w_owner_active = w_active[r_owner];

   // Next state: grant on any activity, release on completion or owner abort.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ARB_IDLE: begin
            if (w_win_valid) begin
               w_state_next = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            if (mem_resp || !w_owner_active) begin
               w_state_next = ARB_IDLE;
            end
         end
         default: w_state_next = ARB_IDLE;
      endcase
   end

   // State, owner and last-grant registers; owner is held through IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ARB_IDLE;
         r_owner      <= '0;
         r_last_grant <= LAST_IDX;
      end else begin
         r_state <= w_state_next;
         if ((r_state == ARB_IDLE) && w_win_valid) begin
            r_owner      <= w_win_idx;
            r_last_grant <= w_win_idx;
         end
      end
   end

   // L2 side carries the owner's slices only while granted.
   assign mem_read  = w_busy & req_read[r_owner];
   assign mem_write = w_busy & req_write[r_owner];
   assign mem_addr  = w_busy ? w_addr_arr[r_owner]  : '0;
   assign mem_wdata = w_busy ? w_wdata_arr[r_owner] : '0;
   assign req_rdata = mem_rdata;
   assign owner     = r_owner;
   assign busy      = w_busy;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Bench for l2_request_arbiter: 2-way fixed, 4-way fixed and 4-way round-robin.
module tb_l2_request_arbiter;
   import arb_pkg::*;

   localparam int LW4 = 32;

   logic clk;
   logic rst_n;

   // 2-way fixed-priority instance (default widths)
   logic [1:0]   rd_a, wr_a, resp_o_a;
   logic [63:0]  addr_a;
   logic [511:0] wdata_a;
   logic [255:0] rdata_o_a, mwdata_a, mrdata_a;
   logic         mrd_a, mwr_a, mresp_a, busy_a;
   logic [31:0]  maddr_a;
   logic [0:0]   owner_a;

   // 4-way instances share the L2 response inputs
   logic [3:0]       rd_f, wr_f, resp_o_f, rd_r, wr_r, resp_o_r;
   logic [127:0]     addr_4;
   logic [4*LW4-1:0] wdata_4;
   logic [LW4-1:0]   rdata_o_f, rdata_o_r, mwdata_f, mwdata_r, mrdata_4;
   logic             mrd_f, mwr_f, busy_f, mrd_r, mwr_r, busy_r, mresp_4;
   logic [31:0]      maddr_f, maddr_r;
   logic [1:0]       owner_f, owner_r;

   // Bench-side view of whichever 4-way instance is under test
   logic           sel_rr;
   logic           busy_x;
   logic [1:0]     owner_x;
   logic [3:0]     resp_x;
   logic [31:0]    maddr_x;
   logic           mrd_x;
   logic [LW4-1:0] rdata_x;
   assign busy_x  = sel_rr ? busy_r    : busy_f;
   assign owner_x = sel_rr ? owner_r   : owner_f;
   assign resp_x  = sel_rr ? resp_o_r  : resp_o_f;
   assign maddr_x = sel_rr ? maddr_r   : maddr_f;
   assign mrd_x   = sel_rr ? mrd_r     : mrd_f;
   assign rdata_x = sel_rr ? rdata_o_r : rdata_o_f;

   typedef struct {
      int          owner;
      logic [31:0] addr;
      logic        is_write;
   } exp_t;

   exp_t sb_a[$];
   int   sb4[$];
   int   n_checks;
   int   n_errors;

   l2_request_arbiter #(.NUM_REQ(2), .RR_MODE(ARB_FIXED)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .req_read(rd_a), .req_write(wr_a),
      .req_addr(addr_a), .req_wdata(wdata_a), .req_rdata(rdata_o_a),
      .req_resp(resp_o_a), .mem_read(mrd_a), .mem_write(mwr_a),
      .mem_addr(maddr_a), .mem_wdata(mwdata_a), .mem_rdata(mrdata_a),
      .mem_resp(mresp_a), .owner(owner_a), .busy(busy_a));

   l2_request_arbiter #(.NUM_REQ(4), .LINE_WIDTH(LW4), .RR_MODE(ARB_FIXED)) u_dut_f (
      .clk(clk), .rst_n(rst_n), .req_read(rd_f), .req_write(wr_f),
      .req_addr(addr_4), .req_wdata(wdata_4), .req_rdata(rdata_o_f),
      .req_resp(resp_o_f), .mem_read(mrd_f), .mem_write(mwr_f),
      .mem_addr(maddr_f), .mem_wdata(mwdata_f), .mem_rdata(mrdata_4),
      .mem_resp(mresp_4), .owner(owner_f), .busy(busy_f));

   l2_request_arbiter #(.NUM_REQ(4), .LINE_WIDTH(LW4), .RR_MODE(ARB_RR)) u_dut_r (
      .clk(clk), .rst_n(rst_n), .req_read(rd_r), .req_write(wr_r),
      .req_addr(addr_4), .req_wdata(wdata_4), .req_rdata(rdata_o_r),
      .req_resp(resp_o_r), .mem_read(mrd_r), .mem_write(mwr_r),
      .mem_addr(maddr_r), .mem_wdata(mwdata_r), .mem_rdata(mrdata_4),
      .mem_resp(mresp_4), .owner(owner_r), .busy(busy_r));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step();
      step();
      n_checks++;
      if ({busy_a, mrd_a, mwr_a, resp_o_a, owner_a} !== 6'b0) begin
         $display("FAIL reset_state: got busy=%b rd=%b wr=%b resp=%b owner=%0d, want all 0",
                  busy_a, mrd_a, mwr_a, resp_o_a, owner_a);
         n_errors++;
      end
      n_checks++;
      if ({busy_r, owner_r, busy_f, owner_f} !== 6'b0) begin
         $display("FAIL reset_state_4: got busy_r=%b owner_r=%0d busy_f=%b owner_f=%0d, want 0",
                  busy_r, owner_r, busy_f, owner_f);
         n_errors++;
      end
      rst_n = 1'b1;
      $display("test_reset: reset state checked");
   endtask

   task automatic test_single();
      exp_t e;
      step();
      addr_a[63:32] = 32'h0000_1000;
      rd_a = 2'b10;
      sb_a.push_back('{owner: 1, addr: 32'h0000_1000, is_write: 1'b0});
      #1;
      n_checks++;
      if (busy_a !== 1'b0 || mrd_a !== 1'b0 || maddr_a !== 32'h0) begin
         $display("FAIL single_idle_zero: busy=%b mem_read=%b mem_addr=%h, want 0/0/0",
                  busy_a, mrd_a, maddr_a);
         n_errors++;
      end
      step();
      e = sb_a.pop_front();
      n_checks++;
      if (mrd_a !== 1'b1 || mwr_a !== 1'b0 || maddr_a !== e.addr || owner_a !== 1'(e.owner)) begin
         $display("FAIL single_grant: rd=%b wr=%b addr=%h owner=%0d, want 1/0/%h/%0d",
                  mrd_a, mwr_a, maddr_a, owner_a, e.addr, e.owner);
         n_errors++;
      end
      step();
      mresp_a  = 1'b1;
      mrdata_a = {8{32'hA5A5_A5A5}};
      #1;
      n_checks++;
      if (resp_o_a !== 2'b10 || rdata_o_a !== {8{32'hA5A5_A5A5}}) begin
         $display("FAIL single_resp: resp=%b rdata=%h, want 10/a5..", resp_o_a, rdata_o_a[31:0]);
         n_errors++;
      end
      step();
      mresp_a = 1'b0;
      rd_a    = 2'b00;
      #1;
      n_checks++;
      if (busy_a !== 1'b0 || resp_o_a !== 2'b00 || owner_a !== 1'b1) begin
         $display("FAIL single_idle_after: busy=%b resp=%b owner=%0d, want 0/00/1 (owner held)",
                  busy_a, resp_o_a, owner_a);
         n_errors++;
      end
      $display("test_single: read from requester 1 at 0x1000 completed");
   endtask

   task automatic test_write();
      exp_t e;
      step();
      wr_a            = 2'b01;
      addr_a[31:0]    = 32'h0000_0040;
      wdata_a[255:0]  = {8{32'hDEAD_BEEF}};
      sb_a.push_back('{owner: 0, addr: 32'h0000_0040, is_write: 1'b1});
      step();
      e = sb_a.pop_front();
      n_checks++;
      if (mwr_a !== e.is_write || mrd_a !== 1'b0 || maddr_a !== e.addr ||
          mwdata_a !== {8{32'hDEAD_BEEF}} || owner_a !== 1'(e.owner)) begin
         $display("FAIL write_grant: wr=%b rd=%b addr=%h wdata=%h owner=%0d, want 1/0/%h/deadbeef../%0d",
                  mwr_a, mrd_a, maddr_a, mwdata_a[31:0], owner_a, e.addr, e.owner);
         n_errors++;
      end
      step();
      mresp_a = 1'b1;
      #1;
      n_checks++;
      if (resp_o_a !== 2'b01) begin
         $display("FAIL write_resp: resp=%b, want 01", resp_o_a);
         n_errors++;
      end
      step();
      mresp_a = 1'b0;
      wr_a    = 2'b00;
      #1;
      n_checks++;
      if (busy_a !== 1'b0 || mwr_a !== 1'b0 || mwdata_a !== '0) begin
         $display("FAIL write_idle: busy=%b wr=%b wdata=%h, want 0/0/0", busy_a, mwr_a, mwdata_a[31:0]);
         n_errors++;
      end
      $display("test_write: write from requester 0 at 0x40 completed");
   endtask

   task automatic test_abort();
      step();
      rd_a = 2'b01;
      step();
      n_checks++;
      if (busy_a !== 1'b1) begin
         $display("FAIL abort_grant: busy=%b, want 1", busy_a);
         n_errors++;
      end
      step();
      rd_a = 2'b00;
      #1;
      n_checks++;
      if (resp_o_a !== 2'b00) begin
         $display("FAIL abort_no_resp: resp=%b, want 00", resp_o_a);
         n_errors++;
      end
      step();
      n_checks++;
      if (busy_a !== 1'b0) begin
         $display("FAIL abort_idle: busy=%b, want 0", busy_a);
         n_errors++;
      end
      mresp_a = 1'b1;
      #1;
      n_checks++;
      if (resp_o_a !== 2'b00) begin
         $display("FAIL stray_resp: resp=%b, want 00", resp_o_a);
         n_errors++;
      end
      step();
      mresp_a = 1'b0;
      #1;
      n_checks++;
      if (busy_a !== 1'b0) begin
         $display("FAIL stray_resp_state: busy=%b, want 0", busy_a);
         n_errors++;
      end
      $display("test_abort: owner dropped request, stray mem_resp ignored");
   endtask

   task automatic test_reset_mid();
      step();
      rd_a = 2'b10;
      step();
      n_checks++;
      if (busy_a !== 1'b1 || mrd_a !== 1'b1) begin
         $display("FAIL reset_mid_setup: busy=%b rd=%b, want 1/1", busy_a, mrd_a);
         n_errors++;
      end
      #2;
      rst_n   = 1'b0;
      mresp_a = 1'b1;
      #1;
      n_checks++;
      if (mrd_a !== 1'b0 || mwr_a !== 1'b0 || busy_a !== 1'b0 ||
          resp_o_a !== 2'b00 || owner_a !== 1'b0) begin
         $display("FAIL reset_mid: rd=%b wr=%b busy=%b resp=%b owner=%0d, want all 0",
                  mrd_a, mwr_a, busy_a, resp_o_a, owner_a);
         n_errors++;
      end
      rd_a    = 2'b00;
      mresp_a = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      mresp_a = 1'b1;
      #1;
      n_checks++;
      if (resp_o_a !== 2'b00 || busy_a !== 1'b0) begin
         $display("FAIL reset_stray_resp: resp=%b busy=%b, want 00/0", resp_o_a, busy_a);
         n_errors++;
      end
      step();
      mresp_a = 1'b0;
      $display("test_reset_mid: async reset dropped the L2 request");
   endtask

   // Serve n grants on the selected 4-way instance, popping expected owners.
   task automatic serve4(input int n, input bit drop_on_done, input bit raise0_first);
      int         cnt;
      int         exp;
      logic [3:0] exp_resp;
      logic [LW4-1:0] rd_val;
      for (int it = 0; it < n; it++) begin
         cnt = 0;
         while (!busy_x && cnt < 8) begin
            step();
            cnt++;
         end
         n_checks++;
         if (!busy_x) begin
            $display("FAIL grant_wait: no grant after %0d cycles (txn %0d)", cnt, it);
            n_errors++;
            return;
         end
         exp = sb4.pop_front();
         n_checks++;
         if (owner_x !== 2'(exp) || mrd_x !== 1'b1 || maddr_x !== 32'h100 + 32'(exp) || cnt != 1) begin
            $display("FAIL grant_%0d: owner=%0d rd=%b addr=%h wait=%0d, want %0d/1/%h/1",
                     it, owner_x, mrd_x, maddr_x, cnt, exp, 32'h100 + 32'(exp));
            n_errors++;
         end
         if (raise0_first && it == 0) begin
            rd_f[0] = 1'b1;
         end
         step();
         rd_val   = LW4'($urandom);
         mresp_4  = 1'b1;
         mrdata_4 = rd_val;
         exp_resp = 4'b0001 << exp;
         #1;
         n_checks++;
         if (resp_x !== exp_resp || owner_x !== 2'(exp) || rdata_x !== rd_val) begin
            $display("FAIL resp_%0d: resp=%b owner=%0d rdata=%h, want %b/%0d/%h",
                     it, resp_x, owner_x, rdata_x, exp_resp, exp, rd_val);
            n_errors++;
         end
         step();
         mresp_4 = 1'b0;
         if (drop_on_done) begin
            if (sel_rr) rd_r[exp] = 1'b0;
            else        rd_f[exp] = 1'b0;
         end
         #1;
         n_checks++;
         if (busy_x !== 1'b0 || resp_x !== 4'b0) begin
            $display("FAIL gap_%0d: busy=%b resp=%b, want 0/0000", it, busy_x, resp_x);
            n_errors++;
         end
         $display("serve4: txn %0d owner %0d rr=%0b", it, exp, sel_rr);
      end
   endtask

   task automatic test_fixed_priority();
      sel_rr = 1'b0;
      step();
      rd_f = 4'b1010;
      sb4.push_back(1);
      sb4.push_back(0);
      sb4.push_back(3);
      #1;
      serve4(3, 1'b1, 1'b1);
      rd_f = 4'b0000;
      step();
      step();
   endtask

   task automatic test_round_robin();
      sel_rr = 1'b1;
      step();
      rd_r = 4'b1111;
      sb4.push_back(0);
      sb4.push_back(1);
      sb4.push_back(2);
      sb4.push_back(3);
      sb4.push_back(0);
      #1;
      serve4(5, 1'b0, 1'b0);
      rd_r = 4'b0000;
      step();
      step();
      step();
      n_checks++;
      if (busy_r !== 1'b0) begin
         $display("FAIL rr_final_idle: busy=%b, want 0", busy_r);
         n_errors++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      sel_rr   = 1'b0;
      rst_n    = 1'b0;
      rd_a = '0; wr_a = '0; addr_a = '0; wdata_a = '0; mrdata_a = '0; mresp_a = 1'b0;
      rd_f = '0; wr_f = '0; rd_r = '0; wr_r = '0; mrdata_4 = '0; mresp_4 = 1'b0;
      wdata_4 = '0;
      for (int i = 0; i < 4; i++) begin
         addr_4[i*32 +: 32] = 32'h100 + 32'(i);
      end
      test_reset();
      test_single();
      test_write();
      test_abort();
      test_fixed_priority();
      test_round_robin();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
